distro_ram_reader: RTL
======================

Name: distro_ram_reader

Overview:
- Read-side stream engine for the distributed dual-port RAM.
- Accepts a burst command (start address, length), drives the RAM's asynchronous read address, and registers the returned word.
- Presents the words as a valid/ready stream with a last flag.
- Sits between a small RAM buffer and its downstream consumer; the write side stays with the producer.

Parameters:
- WIDTH, 8: data word width; must match the RAM.
- LOG_DEP, 3: address width; RAM depth is DEPTH = 1 << LOG_DEP.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  burst command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high
- cmd_addr  in  LOG_DEP  burst start address
- cmd_len  in  LOG_DEP+1  word count, 0..DEPTH
- raddr  out  LOG_DEP  RAM read address, driven from a register
- rdout  in  WIDTH  RAM asynchronous read data
- wen  in  1  RAM write-enable snoop (used only with the optional feature)
- waddr  in  LOG_DEP  RAM write address snoop (optional feature only)
- din  in  WIDTH  RAM write data snoop (optional feature only)
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  WIDTH  output word
- out_last  out  1  marks the final word of the burst
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state=IDLE; rd_addr=0; remaining=0.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - cmd_ready=1 from the first non-reset cycle.
  - Asserting reset mid-burst aborts it; the pending output word is discarded.
- cmd_ready = (state==IDLE), combinational. A command is accepted on a rising edge where cmd_valid && cmd_ready.
- Command with cmd_len==0: accepted, produces no output, state stays IDLE.
- Command with cmd_len>0: rd_addr<=cmd_addr, remaining<=cmd_len, state<=READ.
- raddr = rd_addr at all times.
- Load condition: state==READ && (!out_valid || out_ready).
- On a load edge:
  - out_data<=rdout; out_valid<=1; out_last<=(remaining==1).
  - rd_addr<=rd_addr+1, wrapping modulo DEPTH (DEPTH-1 -> 0).
  - remaining<=remaining-1.
  - If remaining==1, state<=DRAIN.
- Output hold: if out_valid && out_ready and no load occurs, out_valid<=0 and out_last<=0 on that edge.
- Stall: while out_valid && !out_ready, out_data, out_last and rd_addr are held stable.
- DRAIN: when out_valid && out_ready && out_last, out_valid<=0, out_last<=0, state<=IDLE. No new command is accepted in that same cycle.
- Latency: command accepted at edge N; first word has out_valid=1 after edge N+1.
- Throughput: with out_ready held high, one word per cycle. A burst of L words occupies L+1 cycles of busy after acceptance.
- A burst of length DEPTH wraps through every address exactly once.
- Without the optional feature, a write to the current raddr on the same edge as a load returns the pre-write RAM contents.

Optional Feature:
- Macro: DISTRO_READER_FWD_EN.
- Defined: on a load edge where wen && waddr==rd_addr, out_data<=din instead of rdout (write-to-read forwarding, returns new data).
- Undefined: wen, waddr and din are ignored (ports stay present); old data is returned.

Decomposition:
- Shared package dart_ram_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_READ=2'd1, ST_DRAIN=2'd2;
  - defaults for WIDTH and LOG_DEP.
- One natural sub-module: distro_rd_outreg, the output holding register. It owns out_valid, out_data and out_last and exposes a load strobe and a "can load" signal.
- The FSM and the address/length counters stay in the top module.

Test Plan:
- Pre-load RAM[0..7]=8'h10..8'h17; cmd_addr=2, cmd_len=3, out_ready=1 -> out_data 8'h12, 8'h13, 8'h14 on consecutive cycles; out_last only on 8'h14; first out_valid one cycle after acceptance; busy low after 4 cycles.
- cmd_addr=6, cmd_len=4 -> raddr sequence 6, 7, 0, 1; data 8'h16, 8'h17, 8'h10, 8'h11.
- cmd_addr=0, cmd_len=8; out_ready toggled 1,0,0,1,... -> all 8 words in order, none lost or duplicated; out_data and out_last stable during stalls.
- cmd_len=0 -> no out_valid ever asserted, busy stays 0, next command accepted on the next cycle.
- Reset asserted for one cycle mid-burst (after 2 of 5 words) -> next cycle out_valid=0, busy=0, cmd_ready=1; a fresh command then behaves normally.
- wen=1, waddr=rd_addr, din=8'hAA on a load edge -> out_data=8'hAA with DISTRO_READER_FWD_EN defined; old RAM value without it.

Source files
------------

// File: rtl/dart_ram_pkg.sv
// Shared definitions for the distributed-RAM stream reader: FSM encoding and default geometry.
package dart_ram_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_LOG_DEP = 3;

endpackage

// File: rtl/distro_ram_reader_if.sv
// Command and output-stream bundle of the RAM reader; slave is the reader, master is its environment.
interface distro_ram_reader_if
    import dart_ram_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LOG_DEP = DEF_LOG_DEP
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [LOG_DEP-1:0] cmd_addr;
    logic [LOG_DEP:0]   cmd_len;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, out_ready,
        output cmd_ready, out_valid, out_data, out_last
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, out_ready,
        input  cmd_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/distro_rd_outreg.sv
// Output holding register: captures a RAM word on load and keeps it until the consumer takes it.
module distro_rd_outreg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             can_load,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    // A new word may enter when the slot is empty or is being emptied this edge.
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/distro_ram_reader.sv
// Burst read engine for the distributed dual-port RAM, streaming words out with a last flag.
// Optional write-to-read forwarding is enabled by defining DISTRO_READER_FWD_EN.
module distro_ram_reader
    import dart_ram_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LOG_DEP = DEF_LOG_DEP
) (
    input  logic                clock,
    input  logic                reset,
    distro_ram_reader_if.slave  bus,
    output logic [LOG_DEP-1:0]  raddr,
    input  logic [WIDTH-1:0]    rdout,
    input  logic                wen,
    input  logic [LOG_DEP-1:0]  waddr,
    input  logic [WIDTH-1:0]    din,
    output logic                busy
);

    logic [1:0]         state;
    logic [LOG_DEP-1:0] rd_addr;
    logic [LOG_DEP:0]   remaining;
    logic               can_load;
    logic               load;
    logic               load_last;
    logic [WIDTH-1:0]   load_data;
    logic               out_valid;
    logic               out_last;
    logic [WIDTH-1:0]   out_data;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign raddr         = rd_addr;
    assign load          = (state == ST_READ) && can_load;
    assign load_last     = (remaining == (LOG_DEP+1)'(1));

`ifdef DISTRO_READER_FWD_EN
    // A same-edge write to the word being read wins over the stale asynchronous read.
    assign load_data = (wen && (waddr == rd_addr)) ? din : rdout;
`else
    logic unused_snoop;
    assign unused_snoop = ^{wen, waddr, din};
    assign load_data    = rdout;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Zero-length commands are accepted but leave the engine idle.
                    if (bus.cmd_valid && (bus.cmd_len != '0)) begin
                        rd_addr   <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (load) begin
                        rd_addr   <= rd_addr + LOG_DEP'(1);
                        remaining <= remaining - (LOG_DEP+1)'(1);
                        if (load_last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && bus.out_ready && out_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    distro_rd_outreg #(.WIDTH(WIDTH)) u_outreg (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .out_ready (bus.out_ready),
        .can_load  (can_load),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;

endmodule
